// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: widths, PC step, the
// default reset PC and the entry format stored in the fetch queue.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] PC_INC           = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instruction;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake. The fetch stage is the master (drives the
// head entry and its valid), decode is the slave (drives ready).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               fetch_valid;
  logic               fetch_ready;
  logic [INSTR_W-1:0] fetch_instruction;
  logic [PC_W-1:0]    fetch_pc;

  modport master (
    output fetch_valid,
    output fetch_instruction,
    output fetch_pc,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_instruction,
    input  fetch_pc,
    output fetch_ready
  );

endinterface

// File: rtl/fetch_unit_fetch_queue.sv
// Small synchronous FIFO of fetch entries. Head entry is presented
// combinationally; flush empties the queue and takes priority over
// push and pop in the same cycle.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int QCNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  fetch_entry_t      din,
  output fetch_entry_t      dout,
  output logic [QCNT_W-1:0] count,
  output logic              full,
  output logic              empty
);

  fetch_entry_t      mem_q [DEPTH];
  fetch_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [QCNT_W-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign full  = (count_q == QCNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + QCNT_W'(push_ok) - QCNT_W'(pop_ok);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the storage is reset too because the head entry is visible on
      // the outputs straight out of reset and must read as zero, not X.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch stage. Drives the instruction memory address,
// captures {pc, instruction} into the fetch queue, and flushes/reloads on a
// control-flow redirect. Also counts every instruction pushed.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2,
  parameter int              CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    program_counter,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  fetch_unit_if.master       fetch_if,
  output logic [CNT_W-1:0]   fetched_count
);

  localparam int QCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  fetched_count_q, fetched_count_d;
  logic              push, pop;
  logic              q_full, q_empty;
  logic [QCNT_W-1:0] q_count;
  fetch_entry_t      q_din, q_dout;

  // Low target bits are dropped by alignment; occupancy is summarised by full/empty.
  logic unused_ok;
  assign unused_ok = ^{redirect_target[1:0], q_count};

  assign program_counter            = pc_q;
  assign fetched_count              = fetched_count_q;
  assign fetch_if.fetch_valid       = ~q_empty;
  assign fetch_if.fetch_instruction = q_dout.instruction;
  assign fetch_if.fetch_pc          = q_dout.pc;

  // Handshake, push decision and next PC / counter; redirect wins over all.
  always_comb begin
    pop             = ~q_empty & fetch_if.fetch_ready;
    push            = ~halt & ~redirect_valid & (~q_full | pop);
    q_din.pc          = pc_q;
    q_din.instruction = instruction_in;
    pc_d            = pc_q;
    fetched_count_d = fetched_count_q;

    if (redirect_valid) begin
      pc_d = align_pc(redirect_target);
    end else if (push) begin
      pc_d            = pc_q + PC_INC;
      fetched_count_d = fetched_count_q + CNT_W'(1);
    end
  end

  // PC and performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      fetched_count_q <= '0;
    end else begin
      pc_q            <= pc_d;
      fetched_count_q <= fetched_count_d;
    end
  end

  fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run compared against a queue-based reference model of the fetch stage.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int                DEPTH = 2;
  localparam logic [31:0]       RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] program_counter;
  logic [31:0] instruction_in;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] fetched_count;

  fetch_unit_if fif ();

  fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .program_counter (program_counter),
    .instruction_in  (instruction_in),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_if        (fif),
    .fetched_count   (fetched_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instruction memory contents: preloaded words, then an address hash.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_4430;
      32'h4:   return 32'h0000_8610;
      32'h8:   return 32'h0000_0431;
      32'hC:   return 32'h0000_8610;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  assign instruction_in = imem(program_counter);

  // Reference model: PC, an ordered list of queued entries, and the counter.
  logic [31:0]  m_pc;
  logic [31:0]  m_cnt;
  fetch_entry_t m_q[$];

  task automatic model_step();
    bit do_pop, do_push;
    if (reset) begin
      m_pc  = RPC;
      m_cnt = 0;
      m_q.delete();
    end else begin
      do_pop  = (m_q.size() > 0) && (fif.fetch_ready === 1'b1);
      do_push = !halt && !redirect_valid && ((m_q.size() < DEPTH) || do_pop);
      if (redirect_valid) begin
        m_q.delete();
        m_pc = {redirect_target[31:2], 2'b00};
      end else begin
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          m_q.push_back('{pc: m_pc, instruction: imem(m_pc)});
          m_pc  = m_pc + 32'd4;
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
  endtask

  // Advance model and DUT by one clock; outputs are sampled 1 time unit later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; fif.fetch_ready = 1'b0;
    cycle();
    cycle();
    checks++; if (program_counter !== RPC) begin failures++; $display("FAIL reset_pc: got %h want %h", program_counter, RPC); end
    checks++; if (fif.fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", fif.fetch_valid); end
    checks++; if (fif.fetch_instruction !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", fif.fetch_instruction); end
    checks++; if (fif.fetch_pc !== 32'h0) begin failures++; $display("FAIL reset_fpc: got %h want 0", fif.fetch_pc); end
    checks++; if (fetched_count !== 32'h0) begin failures++; $display("FAIL reset_count: got %0d want 0", fetched_count); end
  endtask

  task automatic test_stream();
    logic [31:0] words [4];
    words[0] = 32'h0000_4430; words[1] = 32'h0000_8610;
    words[2] = 32'h0000_0431; words[3] = 32'h0000_8610;
    reset = 1'b0; fif.fetch_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++; if (fif.fetch_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b want 1", k, fif.fetch_valid); end
      checks++; if (fif.fetch_pc !== 32'(4 * k)) begin failures++; $display("FAIL stream_pc[%0d]: got %h want %h", k, fif.fetch_pc, 32'(4 * k)); end
      checks++; if (fif.fetch_instruction !== words[k]) begin failures++; $display("FAIL stream_instr[%0d]: got %h want %h", k, fif.fetch_instruction, words[k]); end
      checks++; if (fetched_count !== 32'(k + 1)) begin failures++; $display("FAIL stream_count[%0d]: got %0d want %0d", k, fetched_count, k + 1); end
    end
  endtask

  task automatic test_backpressure();
    reset = 1'b1; fif.fetch_ready = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    checks++; if (program_counter !== 32'h8) begin failures++; $display("FAIL bp_pc: got %h want 8", program_counter); end
    checks++; if (fetched_count !== 32'd2) begin failures++; $display("FAIL bp_count: got %0d want 2", fetched_count); end
    cycle();
    checks++; if (program_counter !== 32'h8) begin failures++; $display("FAIL bp_pc_hold: got %h want 8", program_counter); end
    checks++; if (fif.fetch_pc !== 32'h0 || fif.fetch_instruction !== 32'h0000_4430) begin
      failures++; $display("FAIL bp_head_hold: got %h/%h want 0/00004430", fif.fetch_pc, fif.fetch_instruction); end
    fif.fetch_ready = 1'b1;
    cycle();
    fif.fetch_ready = 1'b0;
    checks++; if (fif.fetch_pc !== 32'h4) begin failures++; $display("FAIL bp_pop_head: got %h want 4", fif.fetch_pc); end
    checks++; if (program_counter !== 32'hC || fetched_count !== 32'd3) begin
      failures++; $display("FAIL bp_pop_push: got pc %h cnt %0d want c/3", program_counter, fetched_count); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_target = 32'h0000_000E;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (fif.fetch_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: got %b want 0", fif.fetch_valid); end
    checks++; if (program_counter !== 32'hC) begin failures++; $display("FAIL redir_pc: got %h want c", program_counter); end
    checks++; if (fetched_count !== 32'd3) begin failures++; $display("FAIL redir_count: got %0d want 3", fetched_count); end
    cycle();
    checks++; if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== 32'hC || fif.fetch_instruction !== 32'h0000_8610) begin
      failures++; $display("FAIL redir_first: got v%b %h/%h want v1 c/00008610", fif.fetch_valid, fif.fetch_pc, fif.fetch_instruction); end
  endtask

  task automatic test_halt();
    logic [31:0] held;
    cycle();  // second entry queued (ready still 0)
    halt = 1'b1; fif.fetch_ready = 1'b1;
    held = program_counter;
    checks++; if (held !== 32'h14) begin failures++; $display("FAIL halt_start_pc: got %h want 14", held); end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++; if (program_counter !== held) begin failures++; $display("FAIL halt_pc[%0d]: got %h want %h", k, program_counter, held); end
      checks++; if (fif.fetch_valid !== (k == 0)) begin failures++; $display("FAIL halt_drain[%0d]: got %b want %b", k, fif.fetch_valid, k == 0); end
    end
    checks++; if (fetched_count !== 32'd5) begin failures++; $display("FAIL halt_count: got %0d want 5", fetched_count); end
  endtask

  task automatic test_wrap();
    halt = 1'b0; fif.fetch_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (program_counter !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_load: got %h want fffffffc", program_counter); end
    cycle();
    checks++; if ($isunknown(program_counter) || program_counter !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want 0", program_counter); end
    checks++; if (fif.fetch_pc !== 32'hFFFF_FFFC || fif.fetch_instruction !== imem(32'hFFFF_FFFC)) begin
      failures++; $display("FAIL wrap_head: got %h/%h want fffffffc/%h", fif.fetch_pc, fif.fetch_instruction, imem(32'hFFFF_FFFC)); end
    cycle();
    checks++; if (fif.fetch_pc !== 32'h0 || fif.fetch_instruction !== 32'h0000_4430) begin
      failures++; $display("FAIL wrap_next: got %h/%h want 0/00004430", fif.fetch_pc, fif.fetch_instruction); end
  endtask

  task automatic test_reset_mid();
    fif.fetch_ready = 1'b0;
    cycle();
    cycle();
    checks++; if (fif.fetch_valid !== 1'b1) begin failures++; $display("FAIL rmid_queued: got %b want 1", fif.fetch_valid); end
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_1234;
    cycle();
    reset = 1'b0; redirect_valid = 1'b0;
    checks++; if (program_counter !== RPC) begin failures++; $display("FAIL rmid_pc: got %h want %h", program_counter, RPC); end
    checks++; if (fif.fetch_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b want 0", fif.fetch_valid); end
    checks++; if (fetched_count !== 32'h0) begin failures++; $display("FAIL rmid_count: got %0d want 0", fetched_count); end
  endtask

  task automatic test_random();
    logic exp_v;
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 59) == 0);
      halt            = ($urandom_range(0, 3) == 0);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom();
      fif.fetch_ready = 1'($urandom_range(0, 1));
      cycle();
      exp_v = (m_q.size() != 0);
      checks++; if (program_counter !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, program_counter, m_pc); end
      checks++; if (fif.fetch_valid !== exp_v) begin failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, fif.fetch_valid, exp_v); end
      checks++; if (fetched_count !== m_cnt) begin failures++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, fetched_count, m_cnt); end
      if (exp_v) begin
        checks++; if (fif.fetch_pc !== m_q[0].pc) begin failures++; $display("FAIL rnd_fpc[%0d]: got %h want %h", i, fif.fetch_pc, m_q[0].pc); end
        checks++; if (fif.fetch_instruction !== m_q[0].instruction) begin
          failures++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, fif.fetch_instruction, m_q[0].instruction); end
      end
    end
    reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
